// File: rtl/conv_ctrl_if.sv
// Handshake, memory-strobe and MAC-control bundle for conv_ctrl.
//   master : controller view (drives readies, memory strobes, MAC enables, output stream)
//   slave  : environment view (drives stream valids, MAC result, output ready)
// Signals:
//   s_valid_x/s_ready_x, s_valid_f/s_ready_f : input vector / filter word streams
//   addr_x/wr_en_x, addr_f/wr_en_f           : external x/f memory ports
//   reset_accum, en_mult_reg, en_adder_reg    : MAC pipeline control
//   accum_in                                  : saturated, ReLU'd MAC result
//   m_valid_y/m_ready_y/m_data_y              : output word stream
interface conv_ctrl_if #(
    parameter int unsigned T = 11
);
    logic         s_valid_x;
    logic         s_ready_x;
    logic         s_valid_f;
    logic         s_ready_f;
    logic [4:0]   addr_x;
    logic         wr_en_x;
    logic [3:0]   addr_f;
    logic         wr_en_f;
    logic         reset_accum;
    logic         en_mult_reg;
    logic         en_adder_reg;
    logic [T-1:0] accum_in;
    logic         m_valid_y;
    logic         m_ready_y;
    logic [T-1:0] m_data_y;

    modport master (
        input  s_valid_x,
        output s_ready_x,
        input  s_valid_f,
        output s_ready_f,
        output addr_x,
        output wr_en_x,
        output addr_f,
        output wr_en_f,
        output reset_accum,
        output en_mult_reg,
        output en_adder_reg,
        input  accum_in,
        output m_valid_y,
        input  m_ready_y,
        output m_data_y
    );

    modport slave (
        output s_valid_x,
        input  s_ready_x,
        output s_valid_f,
        input  s_ready_f,
        input  addr_x,
        input  wr_en_x,
        input  addr_f,
        input  wr_en_f,
        input  reset_accum,
        input  en_mult_reg,
        input  en_adder_reg,
        output accum_in,
        input  m_valid_y,
        output m_ready_y,
        input  m_data_y
    );
endinterface

// File: rtl/conv_ctrl.sv
// 1-D valid convolution controller: loads an N-word vector and M-tap filter
// into external synchronous memories, then sequences an external MAC pipeline
// once per output position j = 0..N-M and streams each result out.
// Ports:
//   clk   : sole clock
//   reset : asynchronous, active-high reset
//   bus   : conv_ctrl_if.master (streams, memory strobes, MAC control)
module conv_ctrl #(
    parameter int unsigned N = 30,
    parameter int unsigned M = 9,
    parameter int unsigned T = 11
) (
    input  logic          clk,
    input  logic          reset,
    conv_ctrl_if.master   bus
);
    localparam int unsigned XW    = $clog2(N + 1);
    localparam int unsigned FW    = $clog2(M + 1);
    localparam int unsigned J_MAX = N - M;
    localparam int unsigned DRAIN_LAST = 2;

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        CLEAR   = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_cnt_q, x_cnt_d;
    logic [FW-1:0]  f_cnt_q, f_cnt_d;
    logic [XW-1:0]  j_q, j_d;
    logic [FW-1:0]  k_q, k_d;
    logic           en_mult_q, en_adder_q;
    logic [T-1:0]   m_data_q, m_data_d;

    logic           s_ready_x_c, s_ready_f_c;
    logic           wr_en_x_c, wr_en_f_c;
    logic [XW-1:0]  addr_x_c;
    logic [FW-1:0]  addr_f_c;
    logic           reset_accum_c;
    logic           issue_c;
    logic           m_valid_c;

    // State, counters, MAC-enable delay line and output data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD;
            x_cnt_q    <= '0;
            f_cnt_q    <= '0;
            j_q        <= '0;
            k_q        <= '0;
            en_mult_q  <= 1'b0;
            en_adder_q <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            x_cnt_q    <= x_cnt_d;
            f_cnt_q    <= f_cnt_d;
            j_q        <= j_d;
            k_q        <= k_d;
            en_mult_q  <= issue_c;
            en_adder_q <= en_mult_q;
            m_data_q   <= m_data_d;
        end
    end

    // Next-state and decoded strobes.
    always_comb begin
        state_d       = state_q;
        x_cnt_d       = x_cnt_q;
        f_cnt_d       = f_cnt_q;
        j_d           = j_q;
        k_d           = k_q;
        m_data_d      = m_data_q;
        s_ready_x_c   = 1'b0;
        s_ready_f_c   = 1'b0;
        wr_en_x_c     = 1'b0;
        wr_en_f_c     = 1'b0;
        addr_x_c      = '0;
        addr_f_c      = '0;
        reset_accum_c = 1'b0;
        issue_c       = 1'b0;
        m_valid_c     = 1'b0;

        case (state_q)
            LOAD: begin
                // Both streams fill independently; counters stop at N and M.
                s_ready_x_c = (x_cnt_q < XW'(N));
                s_ready_f_c = (f_cnt_q < FW'(M));
                wr_en_x_c   = bus.s_valid_x & s_ready_x_c;
                wr_en_f_c   = bus.s_valid_f & s_ready_f_c;
                if (s_ready_x_c) addr_x_c = x_cnt_q;
                if (s_ready_f_c) addr_f_c = f_cnt_q;
                if (wr_en_x_c) x_cnt_d = x_cnt_q + XW'(1);
                if (wr_en_f_c) f_cnt_d = f_cnt_q + FW'(1);
                if ((x_cnt_q == XW'(N)) && (f_cnt_q == FW'(M))) begin
                    j_d     = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                reset_accum_c = 1'b1;
                k_d           = '0;
                state_d       = COMPUTE;
            end
            COMPUTE: begin
                // One tap per cycle; memory data arrives one cycle later.
                issue_c  = 1'b1;
                addr_x_c = j_q + XW'(k_q);
                addr_f_c = k_q;
                if (k_q == FW'(M - 1)) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + FW'(1);
                end
            end
            DRAIN: begin
                // Wait out read latency, product and accumulator stages.
                if (k_q == FW'(DRAIN_LAST)) begin
                    m_data_d = bus.accum_in;
                    k_d      = '0;
                    state_d  = OUT;
                end else begin
                    k_d = k_q + FW'(1);
                end
            end
            OUT: begin
                m_valid_c = 1'b1;
                if (bus.m_ready_y) begin
                    if (j_q == XW'(J_MAX)) begin
                        j_d     = '0;
                        x_cnt_d = '0;
                        f_cnt_d = '0;
                        state_d = LOAD;
                    end else begin
                        j_d     = j_q + XW'(1);
                        state_d = CLEAR;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Write strobes depend on the live valid, so gate them off during reset.
    assign bus.s_ready_x    = s_ready_x_c;
    assign bus.s_ready_f    = s_ready_f_c;
    assign bus.wr_en_x      = wr_en_x_c & ~reset;
    assign bus.wr_en_f      = wr_en_f_c & ~reset;
    assign bus.addr_x       = addr_x_c;
    assign bus.addr_f       = addr_f_c;
    assign bus.reset_accum  = reset_accum_c;
    assign bus.en_mult_reg  = en_mult_q;
    assign bus.en_adder_reg = en_adder_q;
    assign bus.m_valid_y    = m_valid_c;
    assign bus.m_data_y     = m_data_q;

endmodule
